// File: rtl/issue_queue_if.sv
// Dispatch, wakeup, issue and occupancy signals of the issue queue.
// slave is the queue's view; master is the surrounding pipeline's.
interface issue_queue_if #(
  parameter int RS_ENTRIES = 8,
  parameter int TAG_W      = 6,
  parameter int DATA_W     = 32
) ();
  localparam int CNT_W = $clog2(RS_ENTRIES) + 1;

  logic              disp_valid;
  logic              disp_ready;
  logic [TAG_W-1:0]  disp_rd_tag;
  logic [TAG_W-1:0]  disp_rs1_tag;
  logic [TAG_W-1:0]  disp_rs2_tag;
  logic              disp_rs1_ready;
  logic              disp_rs2_ready;
  logic [DATA_W-1:0] disp_rs1_value;
  logic [DATA_W-1:0] disp_rs2_value;
  logic [DATA_W-1:0] disp_imm;
  logic              disp_alusrc;
  logic [3:0]        disp_alucontrol;
  logic              disp_regwrite;

  logic              wakeup_active;
  logic [TAG_W-1:0]  wakeup_tag;
  logic [DATA_W-1:0] wakeup_value;

  logic              issue_valid;
  logic              issue_ready;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic [DATA_W-1:0] issue_op1;
  logic [DATA_W-1:0] issue_op2;
  logic [3:0]        issue_alucontrol;
  logic              issue_regwrite;

  logic [CNT_W-1:0]  rs_count;

  modport slave (
    input  disp_valid, disp_rd_tag, disp_rs1_tag, disp_rs2_tag, disp_rs1_ready,
           disp_rs2_ready, disp_rs1_value, disp_rs2_value, disp_imm, disp_alusrc,
           disp_alucontrol, disp_regwrite, wakeup_active, wakeup_tag, wakeup_value,
           issue_ready,
    output disp_ready, issue_valid, issue_rd_tag, issue_op1, issue_op2,
           issue_alucontrol, issue_regwrite, rs_count
  );

  modport master (
    output disp_valid, disp_rd_tag, disp_rs1_tag, disp_rs2_tag, disp_rs1_ready,
           disp_rs2_ready, disp_rs1_value, disp_rs2_value, disp_imm, disp_alusrc,
           disp_alucontrol, disp_regwrite, wakeup_active, wakeup_tag, wakeup_value,
           issue_ready,
    input  disp_ready, issue_valid, issue_rd_tag, issue_op1, issue_op2,
           issue_alucontrol, issue_regwrite, rs_count
  );
endinterface

// File: rtl/issue_queue.sv
// Single-issue reservation station: per-entry operand capture from the wakeup
// bus, lowest-index ready select into a registered valid/ready issue slot.
module iq_entry #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              clr_i,
  input  logic [TAG_W-1:0]  wr_rd_tag_i,
  input  logic [TAG_W-1:0]  wr_s1_tag_i,
  input  logic [TAG_W-1:0]  wr_s2_tag_i,
  input  logic              wr_s1_rdy_i,
  input  logic              wr_s2_rdy_i,
  input  logic [DATA_W-1:0] wr_s1_val_i,
  input  logic [DATA_W-1:0] wr_s2_val_i,
  input  logic [3:0]        wr_alu_i,
  input  logic              wr_rw_i,
  input  logic              wk_act_i,
  input  logic [TAG_W-1:0]  wk_tag_i,
  input  logic [DATA_W-1:0] wk_val_i,
  output logic              vld_o,
  output logic              rdy_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] op1_o,
  output logic [DATA_W-1:0] op2_o,
  output logic [3:0]        alu_o,
  output logic              rw_o
);
  // The immediate is folded into s2_val at dispatch, so no imm/alusrc storage.
  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  s1_tag;
    logic [TAG_W-1:0]  s2_tag;
    logic              s1_rdy;
    logic              s2_rdy;
    logic [DATA_W-1:0] s1_val;
    logic [DATA_W-1:0] s2_val;
    logic [3:0]        alu;
    logic              rw;
  } ent_t;

  ent_t ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (wr_en_i) begin
      ent_d.vld    = 1'b1;
      ent_d.rd_tag = wr_rd_tag_i;
      ent_d.s1_tag = wr_s1_tag_i;
      ent_d.s2_tag = wr_s2_tag_i;
      ent_d.s1_rdy = wr_s1_rdy_i;
      ent_d.s2_rdy = wr_s2_rdy_i;
      ent_d.s1_val = wr_s1_val_i;
      ent_d.s2_val = wr_s2_val_i;
      ent_d.alu    = wr_alu_i;
      ent_d.rw     = wr_rw_i;
    end else begin
      if (clr_i) ent_d.vld = 1'b0;
      if (ent_q.vld && !ent_q.s1_rdy && wk_act_i && ent_q.s1_tag == wk_tag_i) begin
        ent_d.s1_rdy = 1'b1;
        ent_d.s1_val = wk_val_i;
      end
      if (ent_q.vld && !ent_q.s2_rdy && wk_act_i && ent_q.s2_tag == wk_tag_i) begin
        ent_d.s2_rdy = 1'b1;
        ent_d.s2_val = wk_val_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ent_q <= '0;
    else       ent_q <= ent_d;
  end

  assign vld_o    = ent_q.vld;
  assign rdy_o    = ent_q.s1_rdy & ent_q.s2_rdy;
  assign rd_tag_o = ent_q.rd_tag;
  assign op1_o    = ent_q.s1_val;
  assign op2_o    = ent_q.s2_val;
  assign alu_o    = ent_q.alu;
  assign rw_o     = ent_q.rw;
endmodule

module issue_queue #(
  parameter int RS_ENTRIES = 8,
  parameter int TAG_W      = 6,
  parameter int DATA_W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  issue_queue_if.slave bus
);
  localparam int CNT_W = $clog2(RS_ENTRIES) + 1;
  localparam int IDX_W = $clog2(RS_ENTRIES);

  logic [RS_ENTRIES-1:0]             ent_vld, ent_rdy, ent_rw, wr_en, clr;
  logic [RS_ENTRIES-1:0][TAG_W-1:0]  ent_rd_tag;
  logic [RS_ENTRIES-1:0][DATA_W-1:0] ent_op1, ent_op2;
  logic [RS_ENTRIES-1:0][3:0]        ent_alu;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              disp_fire, free_found, cand_vld, slot_load;
  logic [IDX_W-1:0]  sel_idx;
  logic              s1_rdy, s2_rdy;
  logic [DATA_W-1:0] s1_val, s2_val;

  logic              slot_vld_q, slot_vld_d, slot_rw_q, slot_rw_d;
  logic [TAG_W-1:0]  slot_tag_q, slot_tag_d;
  logic [DATA_W-1:0] slot_op1_q, slot_op1_d, slot_op2_q, slot_op2_d;
  logic [3:0]        slot_alu_q, slot_alu_d;

  assign bus.disp_ready = (cnt_q != CNT_W'(RS_ENTRIES));
  assign disp_fire      = bus.disp_valid & bus.disp_ready;

  // Same-cycle wakeup is bypassed into the write so the broadcast is not missed.
  always_comb begin
    s1_rdy = bus.disp_rs1_ready;
    s1_val = bus.disp_rs1_value;
    if (!bus.disp_rs1_ready && bus.wakeup_active && bus.disp_rs1_tag == bus.wakeup_tag) begin
      s1_rdy = 1'b1;
      s1_val = bus.wakeup_value;
    end
    s2_rdy = bus.disp_rs2_ready;
    s2_val = bus.disp_rs2_value;
    if (bus.disp_alusrc) begin
      s2_rdy = 1'b1;
      s2_val = bus.disp_imm;
    end else if (!bus.disp_rs2_ready && bus.wakeup_active && bus.disp_rs2_tag == bus.wakeup_tag) begin
      s2_rdy = 1'b1;
      s2_val = bus.wakeup_value;
    end
  end

  always_comb begin
    wr_en      = '0;
    free_found = 1'b0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!ent_vld[i] && !free_found) begin
        free_found = 1'b1;
        wr_en[i]   = disp_fire;
      end
    end
  end

  always_comb begin
    cand_vld = 1'b0;
    sel_idx  = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (ent_vld[i] && ent_rdy[i] && !cand_vld) begin
        cand_vld = 1'b1;
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign slot_load = (!slot_vld_q || bus.issue_ready) && cand_vld;

  always_comb begin
    clr = '0;
    clr[sel_idx] = slot_load;
  end

  for (genvar g = 0; g < RS_ENTRIES; g++) begin : g_ent
    iq_entry #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_ent (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wr_en_i     (wr_en[g]),
      .clr_i       (clr[g]),
      .wr_rd_tag_i (bus.disp_rd_tag),
      .wr_s1_tag_i (bus.disp_rs1_tag),
      .wr_s2_tag_i (bus.disp_rs2_tag),
      .wr_s1_rdy_i (s1_rdy),
      .wr_s2_rdy_i (s2_rdy),
      .wr_s1_val_i (s1_val),
      .wr_s2_val_i (s2_val),
      .wr_alu_i    (bus.disp_alucontrol),
      .wr_rw_i     (bus.disp_regwrite),
      .wk_act_i    (bus.wakeup_active),
      .wk_tag_i    (bus.wakeup_tag),
      .wk_val_i    (bus.wakeup_value),
      .vld_o       (ent_vld[g]),
      .rdy_o       (ent_rdy[g]),
      .rd_tag_o    (ent_rd_tag[g]),
      .op1_o       (ent_op1[g]),
      .op2_o       (ent_op2[g]),
      .alu_o       (ent_alu[g]),
      .rw_o        (ent_rw[g])
    );
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_tag_d = slot_tag_q;
    slot_op1_d = slot_op1_q;
    slot_op2_d = slot_op2_q;
    slot_alu_d = slot_alu_q;
    slot_rw_d  = slot_rw_q;
    if (slot_load) begin
      slot_vld_d = 1'b1;
      slot_tag_d = ent_rd_tag[sel_idx];
      slot_op1_d = ent_op1[sel_idx];
      slot_op2_d = ent_op2[sel_idx];
      slot_alu_d = ent_alu[sel_idx];
      slot_rw_d  = ent_rw[sel_idx];
    end else if (bus.issue_ready) begin
      slot_vld_d = 1'b0;
    end
  end

  assign cnt_d = cnt_q + CNT_W'(disp_fire) - CNT_W'(slot_load);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      slot_vld_q <= 1'b0;
      slot_tag_q <= '0;
      slot_op1_q <= '0;
      slot_op2_q <= '0;
      slot_alu_q <= '0;
      slot_rw_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      slot_vld_q <= slot_vld_d;
      slot_tag_q <= slot_tag_d;
      slot_op1_q <= slot_op1_d;
      slot_op2_q <= slot_op2_d;
      slot_alu_q <= slot_alu_d;
      slot_rw_q  <= slot_rw_d;
    end
  end

  assign bus.issue_valid      = slot_vld_q;
  assign bus.issue_rd_tag     = slot_tag_q;
  assign bus.issue_op1        = slot_op1_q;
  assign bus.issue_op2        = slot_op2_q;
  assign bus.issue_alucontrol = slot_alu_q;
  assign bus.issue_regwrite   = slot_rw_q;
  assign bus.rs_count         = cnt_q;
endmodule

// File: doc/issue_queue.md
# issue_queue

Single-issue reservation station between Rename and the ALU in the out-of-order RISC-V core. Accepts renamed micro-ops whose operands may still be pending and captures operand values from the result-broadcast (wakeup) bus. Selects one fully-ready entry per cycle into a registered issue slot that drives the ALU through a valid/ready handshake.

## Interface
- RS_ENTRIES, 8, number of station entries (power of two, ≥2)
- TAG_W, 6, physical register tag width
- DATA_W, 32, operand/immediate width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept (not full)
- disp_rd_tag  in  TAG_W  destination physical tag
- disp_rs1_tag, disp_rs2_tag  in  TAG_W  source physical tags
- disp_rs1_ready, disp_rs2_ready  in  1  source value already available
- disp_rs1_value, disp_rs2_value  in  DATA_W  source values (valid when ready)
- disp_imm  in  DATA_W  immediate
- disp_alusrc  in  1  1 = op2 is imm, rs2 ignored
- disp_alucontrol  in  4  ALU operation
- disp_regwrite  in  1  result writes rd
- wakeup_active  in  1  broadcast valid
- wakeup_tag  in  TAG_W  broadcast tag
- wakeup_value  in  DATA_W  broadcast value
- issue_valid  out  1  issue slot holds an op
- issue_ready  in  1  ALU accepts op this cycle
- issue_rd_tag  out  TAG_W; issue_op1, issue_op2  out  DATA_W; issue_alucontrol  out  4; issue_regwrite  out  1
- rs_count  out  $clog2(RS_ENTRIES)+1  occupied entries (excludes issue slot)

## Operation
- Entry state: valid, rd_tag, per source {tag, rdy, value}, imm, alusrc, alucontrol, regwrite.
- Dispatch: accepted when disp_valid && disp_ready; written to lowest-index invalid entry. alusrc=1 forces src2 rdy=1 and src2 value := imm.
- Wakeup: every valid entry whose source has rdy=0 and tag == wakeup_tag when wakeup_active sets rdy=1, value := wakeup_value. Applies to both sources independently.
- Dispatch bypass: if the dispatching op’s source has ready=0 and matches an active wakeup in the same cycle, it is written with rdy=1 and wakeup_value.
- Select: candidate = lowest-index valid entry with both rdy bits set (registered state only).
- Issue slot: loaded when (slot empty or issue_ready) and a candidate exists; the candidate entry is invalidated on the same edge. op1 = src1 value, op2 = src2 value. If no candidate and issue_ready, slot empties.
- Slot contents stay stable while issue_valid && !issue_ready.
- disp_ready = (rs_count != RS_ENTRIES), from registered state only; no combinational path from issue_ready or disp_valid.
- rs_count: +1 on dispatch, −1 on slot load, both same edge → unchanged.

## Timing
- Reset (async): all entries invalid, issue_valid=0, issue outputs 0, rs_count=0, disp_ready=1.
- Reset asserted mid-operation discards all entries and the slot content; no op issues from before reset.
- Latency: op dispatched with both sources ready at edge E0 → slot loaded at E1 → issue_valid high the cycle after E1 (2 cycles min).
- Op woken at edge W → earliest slot load at W+1.
- Full station + slot load same edge: disp_ready still 0 that cycle; rises the next cycle.
- Back-to-back: with issue_ready held 1 and candidates available, one op issues per cycle.
- Wakeup for a tag no entry waits on: no effect.

## Test plan
- Reset then dispatch add (rs1=5, rs2=7, both ready, alucontrol=0) → issue_valid 2 cycles later, op1=5, op2=7, rs_count 1→0.
- Dispatch with rs1_tag=12 not ready, rs2 ready=3; wakeup tag 12 value 0x100 three cycles later → issue op1=0x100, op2=3 two cycles after wakeup.
- Dispatch with alusrc=1, imm=0xFFFFFFF0, rs2 not ready → issues without wakeup, op2=0xFFFFFFF0.
- Fill 8 entries with pending ops, issue_ready=0 → disp_ready=0, rs_count=8; wake one → slot loads, disp_ready=1 next cycle.
- Dispatch with rs1_tag=9 not ready while wakeup_active tag 9 value 0xAB same cycle → entry captured ready; issues with op1=0xAB, no further wakeup.
- Hold issue_ready=0 with slot full for 5 cycles while other entries wake → slot outputs unchanged; assert reset mid-stall → issue_valid=0, rs_count=0 immediately.
